uart_lock_status_tx: RTL and testbench

Reports the lock state back to the host over the UART return line. The block watches the `lock_open` output of the lock controller and, on every state change or explicit request, serialises an ASCII status message ("OPEN\r\n" or "CLOSED\r\n") as 8N1 UART frames on `tx_pin`. It pairs with the command receiver on the same link, runs on the same clock with the same bit timing, and contains its own byte serializer, message sequencer and request coalescing.

---
 rtl/uart_lock_status_tx.sv | 190 +++++++++++++++++++
 tb/tb_uart_lock_status_tx.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lock_status_tx.sv
// Lock status reporter: on a lock_open change or report_req, sends "OPEN\r\n"
// or "CLOSED\r\n" as 8N1 frames on tx_pin. Triggers during a message coalesce.
module uart_lock_status_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_open,
    input  logic report_req,
    output logic tx_pin,
    output logic tx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    function automatic logic [7:0] msg_rom(input logic sel_open, input logic [2:0] idx);
        logic [7:0] b;
        case ({sel_open, idx})
            4'b1_000: b = 8'h4F;
            4'b1_001: b = 8'h50;
            4'b1_010: b = 8'h45;
            4'b1_011: b = 8'h4E;
            4'b1_100: b = 8'h0D;
            4'b1_101: b = 8'h0A;
            4'b0_000: b = 8'h43;
            4'b0_001: b = 8'h4C;
            4'b0_010: b = 8'h4F;
            4'b0_011: b = 8'h53;
            4'b0_100: b = 8'h45;
            4'b0_101: b = 8'h44;
            4'b0_110: b = 8'h0D;
            4'b0_111: b = 8'h0A;
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [2:0]     byte_idx_q, byte_idx_d;
    logic           msg_sel_q, msg_sel_d;
    logic           pending_q, pending_d;
    logic           lock_prev_q;
    logic           tx_pin_q, tx_pin_d;
    logic           tx_busy_q, tx_busy_d;

    logic           trigger_s;
    logic           cnt_done_s;
    logic           last_byte_s;
    logic [7:0]     cur_byte_s;

    assign trigger_s   = (lock_open != lock_prev_q) | report_req;
    assign cnt_done_s  = (clk_cnt_q == CNT_LAST);
    assign last_byte_s = msg_sel_q ? (byte_idx_q == 3'd5) : (byte_idx_q == 3'd7);
    assign cur_byte_s  = msg_rom(msg_sel_q, byte_idx_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 3'd0;
            msg_sel_q   <= 1'b0;
            pending_q   <= 1'b0;
            lock_prev_q <= 1'b0;
            tx_pin_q    <= 1'b1;
            tx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            msg_sel_q   <= msg_sel_d;
            pending_q   <= pending_d;
            lock_prev_q <= lock_open;
            tx_pin_q    <= tx_pin_d;
            tx_busy_q   <= tx_busy_d;
        end
    end

    // Next-state, bit timing and request coalescing
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        msg_sel_d  = msg_sel_q;
        // A fresh trigger wins over the acceptance that clears pending
        if (trigger_s) begin
            pending_d = 1'b1;
        end else if (state_q == S_IDLE) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d    = S_START;
                    msg_sel_d  = lock_open;
                    byte_idx_d = 3'd0;
                    bit_idx_d  = 3'd0;
                    clk_cnt_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_done_s) begin
                    state_d   = S_DATA;
                    clk_cnt_d = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_done_s) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_done_s) begin
                    clk_cnt_d = '0;
                    if (last_byte_s) begin
                        state_d = S_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = S_START;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level and busy flag, registered so tx_pin never glitches
    always_comb begin
        tx_pin_d  = 1'b1;
        tx_busy_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_pin_d  = 1'b1;
                tx_busy_d = 1'b0;
            end
            S_START: begin
                tx_pin_d  = 1'b0;
                tx_busy_d = 1'b1;
            end
            S_DATA: begin
                tx_pin_d  = cur_byte_s[bit_idx_q];
                tx_busy_d = 1'b1;
            end
            S_STOP: begin
                tx_pin_d  = 1'b1;
                tx_busy_d = 1'b1;
            end
            default: begin
                tx_pin_d  = 1'b1;
                tx_busy_d = 1'b0;
            end
        endcase
    end

    assign tx_pin  = tx_pin_q;
    assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_lock_status_tx.sv
// Bench for uart_lock_status_tx: two instances (4 and 434 clocks per bit)
// checked cycle by cycle against a message-level model plus a UART receiver.
module tb_uart_lock_status_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic lock0 = 1'b0, req0 = 1'b0, rstn0 = 1'b0;
    logic lock1 = 1'b0, req1 = 1'b0, rstn1 = 1'b0;
    logic pin0, busy0, pin1, busy1;
    logic [1:0] lock_v, req_v, rstn_v, pin_v, busy_v;

    assign lock_v = {lock1, lock0};
    assign req_v  = {req1, req0};
    assign rstn_v = {rstn1, rstn0};
    assign pin_v  = {pin1, pin0};
    assign busy_v = {busy1, busy0};

    uart_lock_status_tx #(.CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .rst(rstn0), .lock_open(lock0), .report_req(req0),
        .tx_pin(pin0), .tx_busy(busy0)
    );

    uart_lock_status_tx #(.CLKS_PER_BIT(434)) dut1 (
        .clk(clk), .rst(rstn1), .lock_open(lock1), .report_req(req1),
        .tx_pin(pin1), .tx_busy(busy1)
    );

    int checks_total = 0;
    int checks_pass  = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks_total++;
        if (got == exp) begin
            checks_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     nm, got, got, exp, exp, $time);
        end
    endtask

    function automatic int cpb_of(input int i);
        return (i == 0) ? 4 : 434;
    endfunction

    function automatic logic [7:0] msg_byte(input logic op, input int idx);
        logic [7:0] b;
        b = 8'h00;
        if (op) begin
            case (idx)
                0: b = 8'h4F; 1: b = 8'h50; 2: b = 8'h45;
                3: b = 8'h4E; 4: b = 8'h0D; 5: b = 8'h0A;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                0: b = 8'h43; 1: b = 8'h4C; 2: b = 8'h4F; 3: b = 8'h53;
                4: b = 8'h45; 5: b = 8'h44; 6: b = 8'h0D; 7: b = 8'h0A;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    // Line level j cycles into a message: 10-bit frames, start 0, LSB first, stop 1
    function automatic logic exp_bit(input logic op, input longint j, input int cpb);
        int b;
        int pos;
        logic [7:0] by;
        b   = int'(j / cpb);
        pos = b % 10;
        by  = msg_byte(op, b / 10);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[pos-1];
    endfunction

    // ---------------- message-level model ----------------
    longint     ecount = 0;
    logic       m_pend[2], m_prev[2], m_active[2], m_op[2];
    longint     m_start[2];
    int         m_len[2], m_msgs[2], m_wr[2];
    logic       exp_pin[2], exp_busy[2];
    logic [7:0] exp_buf[2][4096];

    task automatic model_step(input int i);
        int     cpb;
        longint j;
        logic   idle, accept, trig;
        cpb = cpb_of(i);
        if (!rstn_v[i]) begin
            m_pend[i] = 1'b0; m_prev[i] = 1'b0; m_active[i] = 1'b0;
            exp_pin[i] = 1'b1; exp_busy[i] = 1'b0;
            return;
        end
        idle   = !m_active[i] || (ecount > m_start[i] + longint'(m_len[i]) * 10 * cpb);
        accept = idle && m_pend[i];
        trig   = (lock_v[i] != m_prev[i]) || req_v[i];
        if (accept) begin
            m_start[i]  = ecount;
            m_op[i]     = lock_v[i];
            m_len[i]    = lock_v[i] ? 6 : 8;
            m_active[i] = 1'b1;
            m_msgs[i]++;
        end
        m_pend[i] = trig || (m_pend[i] && !accept);
        m_prev[i] = lock_v[i];
        exp_pin[i] = 1'b1; exp_busy[i] = 1'b0;
        if (m_active[i]) begin
            j = ecount - m_start[i] - 1;
            if (j >= 0 && j < longint'(m_len[i]) * 10 * cpb) begin
                exp_busy[i] = 1'b1;
                exp_pin[i]  = exp_bit(m_op[i], j, cpb);
                // a byte is committed once its stop bit starts
                if (j % (10 * cpb) == 9 * cpb && m_wr[i] < 4096) begin
                    exp_buf[i][m_wr[i]] = msg_byte(m_op[i], int'(j / (10 * cpb)));
                    m_wr[i]++;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0; m_prev[i] = 1'b0; m_active[i] = 1'b0; m_op[i] = 1'b0;
            m_start[i] = 0; m_len[i] = 0; m_msgs[i] = 0; m_wr[i] = 0;
            exp_pin[i] = 1'b1; exp_busy[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            ecount++;
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // ---------------- compare process and UART receiver ----------------
    logic       rx_act[2];
    int         rx_t[2], rx_rd[2], rx_n[2];
    logic [7:0] rx_sh[2];
    logic [7:0] rx_log[2][4096];
    int         act[2], b_run[2], lo_run[2], last_blen[2], last_gap[2];

    task automatic rx_step(input int i);
        int cpb, h, k;
        cpb = cpb_of(i);
        h   = cpb / 2;
        if (!rstn_v[i]) begin
            rx_act[i] = 1'b0;
        end else if (!rx_act[i]) begin
            if (!pin_v[i]) begin
                rx_act[i] = 1'b1; rx_t[i] = 0; rx_sh[i] = 8'h00;
            end
        end else begin
            rx_t[i]++;
            if (rx_t[i] >= cpb + h && (rx_t[i] - h) % cpb == 0) begin
                k = (rx_t[i] - h) / cpb;
                if (k <= 8) begin
                    rx_sh[i][k-1] = pin_v[i];
                end else begin
                    chk("rx_stop_bit", longint'(pin_v[i]), 1);
                    if (rx_n[i] < 4096) rx_log[i][rx_n[i]] = rx_sh[i];
                    rx_n[i]++;
                    if (rx_rd[i] < m_wr[i]) begin
                        chk("rx_byte_vs_model", longint'(rx_sh[i]), longint'(exp_buf[i][rx_rd[i]]));
                        rx_rd[i]++;
                    end else begin
                        checks_total++;
                        $display("FAIL rx_unexpected_byte: got 0x%0h, expected no byte (inst %0d)", rx_sh[i], i);
                    end
                    rx_act[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rx_act[i] = 1'b0; rx_t[i] = 0; rx_rd[i] = 0; rx_n[i] = 0; rx_sh[i] = 8'h00;
            act[i] = 0; b_run[i] = 0; lo_run[i] = 0; last_blen[i] = 0; last_gap[i] = 0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                chk(i == 0 ? "line0_pin_busy" : "line1_pin_busy",
                    longint'({pin_v[i], busy_v[i]}), longint'({exp_pin[i], exp_busy[i]}));
                if (!pin_v[i] || busy_v[i]) act[i]++;
                if (busy_v[i]) begin
                    if (b_run[i] == 0) begin
                        last_gap[i] = lo_run[i];
                        lo_run[i]   = 0;
                    end
                    b_run[i]++;
                end else begin
                    if (b_run[i] > 0) last_blen[i] = b_run[i];
                    b_run[i] = 0;
                    lo_run[i]++;
                end
                rx_step(i);
            end
        end
    end

    // ---------------- stimulus helpers (instance 0) ----------------
    task automatic sample();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_busy0(input logic lvl, input int bound, input string nm);
        int n;
        n = 0;
        while (busy0 !== lvl && n < bound) begin
            sample();
            n++;
        end
        if (busy0 !== lvl) chk(nm, longint'(busy0), longint'(lvl));
    endtask

    task automatic check_msg(input int i, input int base, input logic op, input string nm);
        int len;
        len = op ? 6 : 8;
        chk({nm, "_count"}, rx_n[i] - base, len);
        for (int k = 0; k < len; k++)
            chk(nm, longint'(rx_log[i][base + k]), longint'(msg_byte(op, k)));
    endtask

    logic done0 = 1'b0, done1 = 1'b0;

    // instance 0 scenarios
    initial begin
        int n0, a0, m0, cnt, r;
        repeat (3) @(negedge clk);
        rstn0 = 1'b1;

        a0 = act[0];
        repeat (1000) @(negedge clk);
        chk("idle_quiet", act[0] - a0, 0);
        chk("idle_no_bytes", rx_n[0], 0);

        // 0 -> 1: OPEN, first start bit 2 edges after the sampling edge
        n0 = rx_n[0];
        @(negedge clk); lock0 = 1'b1;
        cnt = 0;
        do begin sample(); cnt++; end while (pin0 && cnt < 20);
        chk("start_latency", cnt - 1, 2);
        wait_busy0(1'b0, 1000, "open_timeout");
        chk("open_busy_len", last_blen[0], 240);
        check_msg(0, n0, 1'b1, "open_bytes");
        chk("open_first_byte_literal", longint'(rx_log[0][n0]), 64'h4F);

        // 1 -> 0: CLOSED
        n0 = rx_n[0];
        @(negedge clk); lock0 = 1'b0;
        wait_busy0(1'b1, 20, "closed_start_timeout");
        wait_busy0(1'b0, 1000, "closed_timeout");
        chk("closed_busy_len", last_blen[0], 320);
        check_msg(0, n0, 1'b0, "closed_bytes");

        // coalescing: open, then 1->0->1 and a request during the message
        n0 = rx_n[0];
        m0 = m_msgs[0];
        @(negedge clk); lock0 = 1'b1;
        repeat (30) @(negedge clk); lock0 = 1'b0;
        repeat (17) @(negedge clk); lock0 = 1'b1;
        repeat (11) @(negedge clk); req0 = 1'b1;
        @(negedge clk); req0 = 1'b0;
        wait_busy0(1'b0, 1000, "coal_first_timeout");
        wait_busy0(1'b1, 5, "coal_second_timeout");
        chk("coal_idle_gap", last_gap[0], 1);
        wait_busy0(1'b0, 1000, "coal_end_timeout");
        repeat (100) @(negedge clk);
        chk("coal_msgs_model", m_msgs[0] - m0, 2);
        chk("coal_total_bytes", rx_n[0] - n0, 12);
        check_msg(0, n0 + 6, 1'b1, "coal_second_bytes");
        chk("coal_second_literal", longint'(rx_log[0][n0 + 9]), 64'h4E);

        // reset in the data bits of the third CLOSED byte
        n0 = rx_n[0];
        @(negedge clk); lock0 = 1'b0;
        wait_busy0(1'b1, 20, "rst_msg_start_timeout");
        repeat (100) @(negedge clk);
        rstn0 = 1'b0;
        #1;
        chk("rst_pin_immediate", longint'(pin0), 1);
        chk("rst_busy_immediate", longint'(busy0), 0);
        repeat (3) @(negedge clk);
        rstn0 = 1'b1;
        chk("rst_bytes_before", rx_n[0] - n0, 2);
        a0 = act[0];
        repeat (300) @(negedge clk);
        chk("rst_quiet_after", act[0] - a0, 0);
        chk("rst_no_bytes_after", rx_n[0] - n0, 2);

        // randomized triggers against the model
        repeat (60) begin
            repeat ($urandom_range(1, 120)) @(negedge clk);
            r = $urandom_range(0, 3);
            if (r == 0) begin
                lock0 = ~lock0;
            end else if (r == 1) begin
                req0 = 1'b1; @(negedge clk); req0 = 1'b0;
            end else if (r == 2) begin
                lock0 = ~lock0; @(negedge clk); lock0 = ~lock0;
            end else begin
                lock0 = ~lock0; req0 = 1'b1; @(negedge clk); req0 = 1'b0;
            end
        end
        cnt = 0;
        r   = 0;
        while (r < 20 && cnt < 5000) begin
            sample();
            cnt++;
            r = busy0 ? 0 : r + 1;
        end
        chk("random_drain", r, 20);
        chk("random_bytes_vs_model", rx_rd[0], m_wr[0]);
        done0 = 1'b1;
    end

    // instance 1: full-rate bit timing on a CLOSED report
    initial begin
        int n1, cnt;
        repeat (3) @(negedge clk);
        rstn1 = 1'b1;
        repeat (10) @(negedge clk);
        n1 = rx_n[1];
        req1 = 1'b1;
        @(negedge clk); req1 = 1'b0;
        cnt = 0;
        do begin sample(); cnt++; end while (pin1 && cnt < 20);
        chk("slow_start_latency", cnt - 1, 1);
        cnt = 0;
        while (!pin1 && cnt < 2000) begin
            cnt++;
            sample();
        end
        chk("slow_start_bit_len", cnt, 434);
        cnt = 0;
        while (busy1 && cnt < 40000) begin
            sample();
            cnt++;
        end
        chk("slow_done", longint'(busy1), 0);
        chk("slow_busy_len", last_blen[1], 34720);
        check_msg(1, n1, 1'b0, "slow_closed_bytes");
        done1 = 1'b1;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: bench still running after 95000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        wait (done0 && done1);
        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
